// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM states and change-coin selection.
package vend_pkg;

   typedef enum logic {
      IDLE,
      CHANGE
   } vend_state_t;

   typedef enum logic [1:0] {
      COIN_NONE,
      COIN_Q,
      COIN_D,
      COIN_N
   } coin_sel_t;

endpackage

// File: rtl/change_pick.sv
// Greedy change selection: picks the largest coin whose value fits in the remaining credit.
module change_pick
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W = 7,
   parameter int unsigned Q_VAL    = 25,
   parameter int unsigned D_VAL    = 10,
   parameter int unsigned N_VAL    = 5
) (
   input  logic [CREDIT_W-1:0] credit,
   output coin_sel_t           sel,
   output logic [CREDIT_W-1:0] value
);

   localparam logic [CREDIT_W-1:0] QV = CREDIT_W'(Q_VAL);
   localparam logic [CREDIT_W-1:0] DV = CREDIT_W'(D_VAL);
   localparam logic [CREDIT_W-1:0] NV = CREDIT_W'(N_VAL);

   always_comb begin
      sel   = COIN_NONE;
      value = '0;
      if (credit >= QV) begin
         sel   = COIN_Q;
         value = QV;
      end else if (credit >= DV) begin
         sel   = COIN_D;
         value = DV;
      end else if (credit >= NV) begin
         sel   = COIN_N;
         value = NV;
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accumulation, vend on Buy, greedy one-coin-per-cycle change.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned PRICE      = 25,
   parameter int unsigned CREDIT_W   = 7,
   parameter int unsigned MAX_CREDIT = 95,
   parameter int unsigned Q_VAL      = 25,
   parameter int unsigned D_VAL      = 10,
   parameter int unsigned N_VAL      = 5
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Quarters,
   input  logic                Dimes,
   input  logic                Nickles,
   input  logic                Buy,
   input  logic                Refund,
   output logic [CREDIT_W-1:0] Credit,
   output logic                Vending,
   output logic                CoinReject,
   output logic                QuarterOut,
   output logic                DimeOut,
   output logic                NickelOut,
   output logic                Busy
);

   // Two spare bits so credit plus a full coin sum can never wrap before the limit check.
   localparam int unsigned SUM_W = CREDIT_W + 2;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [SUM_W-1:0]    MAX_C   = SUM_W'(MAX_CREDIT);

   vend_state_t         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                vend_q, vend_d;
   logic                reject_q, reject_d;
   logic                qout_q, qout_d;
   logic                dout_q, dout_d;
   logic                nout_q, nout_d;

   logic                any_coin;
   logic [SUM_W-1:0]    coin_sum;
   logic [SUM_W-1:0]    credit_sum;
   coin_sel_t           pick_sel;
   logic [CREDIT_W-1:0] pick_value;

   change_pick #(
      .CREDIT_W (CREDIT_W),
      .Q_VAL    (Q_VAL),
      .D_VAL    (D_VAL),
      .N_VAL    (N_VAL)
   ) u_change_pick (
      .credit (credit_q),
      .sel    (pick_sel),
      .value  (pick_value)
   );

   always_comb begin
      any_coin   = Quarters | Dimes | Nickles;
      coin_sum   = (Quarters ? SUM_W'(Q_VAL) : '0)
                 + (Dimes    ? SUM_W'(D_VAL) : '0)
                 + (Nickles  ? SUM_W'(N_VAL) : '0);
      credit_sum = SUM_W'(credit_q) + coin_sum;
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      vend_d   = 1'b0;
      reject_d = 1'b0;
      qout_d   = 1'b0;
      dout_d   = 1'b0;
      nout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Refund && (credit_q != '0)) begin
               state_d  = CHANGE;
               reject_d = any_coin;
            end else if (Buy && (credit_q >= PRICE_C)) begin
               vend_d   = 1'b1;
               credit_d = credit_q - PRICE_C;
               reject_d = any_coin;
            end else if (any_coin) begin
               if (credit_sum <= MAX_C) begin
                  credit_d = credit_sum[CREDIT_W-1:0];
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         CHANGE: begin
            reject_d = any_coin;
            if (pick_sel == COIN_NONE) begin
               // Any residue below the smallest coin is forfeited.
               credit_d = '0;
               state_d  = IDLE;
            end else begin
               credit_d = credit_q - pick_value;
               qout_d   = (pick_sel == COIN_Q);
               dout_d   = (pick_sel == COIN_D);
               nout_d   = (pick_sel == COIN_N);
            end
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         credit_q <= '0;
         vend_q   <= 1'b0;
         reject_q <= 1'b0;
         qout_q   <= 1'b0;
         dout_q   <= 1'b0;
         nout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         vend_q   <= vend_d;
         reject_q <= reject_d;
         qout_q   <= qout_d;
         dout_q   <= dout_d;
         nout_q   <= nout_d;
      end
   end

   assign Credit     = credit_q;
   assign Vending    = vend_q;
   assign CoinReject = reject_q;
   assign QuarterOut = qout_q;
   assign DimeOut    = dout_q;
   assign NickelOut  = nout_q;
   assign Busy       = (state_q == CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: trace-based reference model plus literal spot checks.
module tb_vend_ctrl;

   localparam int PRICE = 25;
   localparam int MAXC  = 95;
   localparam int QV    = 25;
   localparam int DV    = 10;
   localparam int NV    = 5;

   logic       Clock, Reset;
   logic       Quarters, Dimes, Nickles, Buy, Refund;
   logic [6:0] Credit;
   logic       Vending, CoinReject, QuarterOut, DimeOut, NickelOut, Busy;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 0;

   vend_ctrl dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Quarters   (Quarters),
      .Dimes      (Dimes),
      .Nickles    (Nickles),
      .Buy        (Buy),
      .Refund     (Refund),
      .Credit     (Credit),
      .Vending    (Vending),
      .CoinReject (CoinReject),
      .QuarterOut (QuarterOut),
      .DimeOut    (DimeOut),
      .NickelOut  (NickelOut),
      .Busy       (Busy)
   );

   initial begin
      Clock = 0;
      forever #5 Clock = ~Clock;
   end

   // Model: a refund precomputes the whole change trace; while it drains, the machine is busy.
   typedef struct {
      int credit;
      bit q;
      bit d;
      bit n;
      bit busy;
   } step_t;

   step_t pend[$];
   int    m_credit;
   bit    m_vend, m_rej, m_q, m_d, m_n, m_busy;

   task automatic model_reset();
      pend.delete();
      m_credit = 0;
      {m_vend, m_rej, m_q, m_d, m_n, m_busy} = '0;
   endtask

   task automatic model_step(input bit q, input bit d, input bit n, input bit b, input bit r);
      step_t s;
      int    c, sum;
      bit    coin;
      coin = q | d | n;
      sum  = (q ? QV : 0) + (d ? DV : 0) + (n ? NV : 0);
      {m_vend, m_rej, m_q, m_d, m_n} = '0;
      if (pend.size() > 0) begin
         s        = pend.pop_front();
         m_credit = s.credit;
         m_q      = s.q;
         m_d      = s.d;
         m_n      = s.n;
         m_busy   = s.busy;
         m_rej    = coin;
      end else begin
         m_busy = 0;
         if (r && m_credit > 0) begin
            m_busy = 1;
            m_rej  = coin;
            c      = m_credit;
            while (c >= NV) begin
               s = '{credit: 0, q: 0, d: 0, n: 0, busy: 1};
               if (c >= QV) begin c -= QV; s.q = 1; end
               else if (c >= DV) begin c -= DV; s.d = 1; end
               else begin c -= NV; s.n = 1; end
               s.credit = c;
               pend.push_back(s);
            end
            pend.push_back('{credit: 0, q: 0, d: 0, n: 0, busy: 0});
         end else if (b && m_credit >= PRICE) begin
            m_vend   = 1;
            m_credit = m_credit - PRICE;
            m_rej    = coin;
         end else if (coin) begin
            if (m_credit + sum <= MAXC) m_credit = m_credit + sum;
            else m_rej = 1;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (check_en) begin
         chk("credit", int'(Credit), m_credit);
         chk("vending", int'(Vending), int'(m_vend));
         chk("coin_reject", int'(CoinReject), int'(m_rej));
         chk("quarter_out", int'(QuarterOut), int'(m_q));
         chk("dime_out", int'(DimeOut), int'(m_d));
         chk("nickel_out", int'(NickelOut), int'(m_n));
         chk("busy", int'(Busy), int'(m_busy));
         chk("onehot_out", int'(QuarterOut) + int'(DimeOut) + int'(NickelOut) > 1, 0);
      end
   end

   // Drives one cycle of inputs now, then steps the model on the following rising edge.
   task automatic tick(input bit q, input bit d, input bit n, input bit b, input bit r);
      Quarters = q;
      Dimes    = d;
      Nickles  = n;
      Buy      = b;
      Refund   = r;
      @(posedge Clock);
      model_step(q, d, n, b, r);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0, 0);
   endtask

   initial begin
      Reset = 1;
      {Quarters, Dimes, Nickles, Buy, Refund} = '0;
      model_reset();
      #1 check_en = 1;
      @(posedge Clock);
      @(negedge Clock);
      chk("reset_credit", int'(Credit), 0);
      chk("reset_busy", int'(Busy), 0);
      #1 Reset = 0;

      // Simultaneous coins, then a purchase.
      tick(1, 1, 1, 0, 0);
      chk("t2_sum", int'(Credit), 40);
      tick(0, 0, 0, 1, 0);
      chk("t2_vend", int'(Vending), 1);
      chk("t2_credit", int'(Credit), 15);

      // Insufficient credit, exact ceiling, over-limit rejection.
      tick(0, 0, 0, 1, 0);
      chk("t3_novend", int'(Vending), 0);
      chk("t3_credit15", int'(Credit), 15);
      tick(1, 1, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      chk("t3_credit85", int'(Credit), 85);
      tick(0, 1, 0, 0, 0);
      chk("t3_credit95", int'(Credit), 95);
      tick(0, 0, 1, 0, 0);
      chk("t3_reject", int'(CoinReject), 1);
      chk("t3_hold95", int'(Credit), 95);

      // Refund of the full ceiling: Q,Q,Q,D,D.
      tick(0, 0, 0, 0, 1);
      idle(7);
      chk("t4a_empty", int'(Credit), 0);

      // Refund of 40 with literal per-cycle expectations.
      tick(1, 1, 1, 0, 0);
      tick(0, 0, 0, 0, 1);
      chk("t4_busy_start", int'(Busy), 1);
      tick(0, 0, 0, 0, 0);
      chk("t4_qout", int'(QuarterOut), 1);
      chk("t4_c15", int'(Credit), 15);
      tick(0, 0, 0, 0, 0);
      chk("t4_dout", int'(DimeOut), 1);
      tick(0, 0, 0, 0, 0);
      chk("t4_nout", int'(NickelOut), 1);
      chk("t4_c0", int'(Credit), 0);
      chk("t4_busy_last", int'(Busy), 1);
      tick(0, 0, 0, 0, 0);
      chk("t4_busy_end", int'(Busy), 0);
      idle(1);

      // Buy+Refund+quarter together at 50: refund wins, coin rejected.
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 1, 1);
      chk("t5_novend", int'(Vending), 0);
      chk("t5_reject", int'(CoinReject), 1);
      chk("t5_c50", int'(Credit), 50);
      tick(0, 0, 0, 0, 0);
      chk("t5_q1", int'(QuarterOut), 1);
      tick(0, 0, 0, 0, 0);
      chk("t5_q2", int'(QuarterOut), 1);
      idle(2);

      // Buy and a dime during CHANGE are ignored / rejected.
      tick(1, 1, 1, 0, 0);
      tick(0, 0, 0, 0, 1);
      tick(0, 1, 0, 1, 0);
      chk("t6_reject", int'(CoinReject), 1);
      chk("t6_qout", int'(QuarterOut), 1);
      chk("t6_c15", int'(Credit), 15);
      tick(0, 0, 0, 1, 0);
      chk("t6_novend", int'(Vending), 0);
      idle(3);

      // Refund with zero credit is ignored.
      tick(0, 0, 0, 0, 1);
      chk("zero_refund_busy", int'(Busy), 0);

      // Reset in the middle of a change sequence.
      tick(1, 1, 1, 0, 0);
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0);
      {Quarters, Dimes, Nickles, Buy, Refund} = '0;
      Reset = 1;
      model_reset();
      #1;
      chk("t1_credit", int'(Credit), 0);
      chk("t1_busy", int'(Busy), 0);
      chk("t1_qout", int'(QuarterOut), 0);
      @(posedge Clock);
      #1 Reset = 0;
      idle(3);
      tick(0, 1, 0, 0, 0);
      chk("post_reset_c10", int'(Credit), 10);
      idle(2);

      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
